rh11_intr: RTL
==============

Name: rh11_intr

Overview:
- RH11 interrupt controller, directly downstream of the CS1 register block.
- Consumes the assembled CS1 word (SC, RDY, IE) and CS1 write strobes, and decides when the RH11 raises a Unibus interrupt request.
- Runs the request/grant handshake with the UBA and supplies the vector.
- Returns the interrupt-acknowledge pulse (rhIACK) that clears CS1[IE].

Parameters:
INTR_LEVEL, 6, Unibus BR level (1..7) driven on devINTR.
INTR_VECT, 16'o000254, interrupt vector presented during grant.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
devRESET  input  1  device reset from UBA
rhCLR  input  1  controller clear (RHCS2[CLR])
rhcs1WRITE  input  1  CS1 register write strobe
devLOBYTE  input  1  low-byte write qualifier
devDATAI  input  36  write data, big-endian [0:35]; bit 6 LE = IE, bit 7 LE = RDY
rhCS1  input  16  CS1 word: [15]=SC, [7]=RDY, [6]=IE
devINTA  input  1  interrupt grant from UBA for this device
devINTR  output  7  [7:1] one-hot BR request; only bit INTR_LEVEL ever set
devVECT  output  16  interrupt vector, valid only during ACK cycle, else 0
rhIACK  output  1  one-cycle acknowledge pulse to CS1 (clears IE)
rhPEND  output  1  interrupt pending (diagnostic/status)

Behaviour:
- Internal edge registers lastRDY and lastSC: sample rhCS1[7] and rhCS1[15] every clk. Reset value 1 for lastRDY, 0 for lastSC, so release from reset with RDY=1 is not an edge.
- Interrupt events (any one sets `pending` on the next clk):
  - E1 done: RDY rising edge (rhCS1[7] & !lastRDY) while rhCS1[6]=1.
  - E2 attention: SC rising edge while rhCS1[7]=1 and rhCS1[6]=1.
  - E3 IE-set-while-ready: rhcs1WRITE & devLOBYTE & devDATAI bit IE=1 & bit RDY=1 & rhCS1[7]=1. A software write that sets IE with RDY=1 forces an interrupt even if IE was already 1.
- States:
  - IDLE: devINTR=0. If pending → REQ next clk.
  - REQ: devINTR[INTR_LEVEL]=1. Transitions:
    - devINTA → ACK.
    - rhCS1[6]=0 and no event this cycle → IDLE with pending cleared (software cancelled IE).
  - ACK: exactly one clk. devVECT=INTR_VECT, rhIACK=1, devINTR=0, pending cleared → IDLE.
- Latencies:
  - Event to devINTR asserted: 2 clk (event → pending, pending → REQ).
  - devINTA to rhIACK: 1 clk.
  - devINTA sampled only in REQ; ignored elsewhere.
- Simultaneous events:
  - Event in the same clk as ACK: pending is set (event wins over the ACK clear), so a second request follows from IDLE.
  - Multiple events in one clk: single pending, no counting.
  - devINTA and IE cleared in the same REQ cycle: grant wins → ACK (vector must be delivered once granted).
- devRESET or rhCLR (synchronous): state→IDLE, pending=0, lastSC=0, lastRDY=rhCS1[7]. Outputs 0 next clk. Takes priority over all events, including mid-REQ and mid-ACK.
- rst (asynchronous): state=IDLE, pending=0, devINTR=0, devVECT=0, rhIACK=0, rhPEND=0, lastRDY=1, lastSC=0.
- rhPEND = pending | (state==REQ).
- devINTR is registered; no combinational path from any input to devINTR.
- devVECT and rhIACK are registered outputs of the ACK state.

Test Plan:
- IE=1, RDY 0→1: devINTR=7'b0100000 two clks later. Pulse devINTA: next clk devVECT=16'o000254, rhIACK=1 for exactly 1 clk. Then devINTR=0 and rhPEND=0.
- RDY=1, IE=0, then CS1 low-byte write with data 16'o000300 (IE=1, RDY=1): interrupt requested. Same write with data 16'o000100 and rhCS1[7]=0: no request.
- IE=1, RDY=1, SC 0→1: request raised. SC held at 1 for 10 clks: only one interrupt after ACK. RDY=0 during the SC edge: no request.
- In REQ, drop rhCS1[6] to 0 without devINTA: devINTR clears next clk, no rhIACK. Repeat with devINTA in the same clk as IE drop: ACK occurs and vector is delivered.
- RDY rising edge (IE=1) in the same clk as ACK: rhIACK pulse, then a second request, devINTR asserted 2 clks later.
- In REQ, assert rhCLR (then separately devRESET, then async rst): devINTR=0, rhPEND=0 next clk (immediately for rst). With RDY=1 held, release produces no spurious request.

Source files
------------

// File: rtl/rh11_intr.sv
// RH11 interrupt controller: turns CS1 done/attention/IE-write events into a
// Unibus BR request, runs the grant handshake and returns the IE-clearing ack.
module rh11_intr #(
    parameter int          INTR_LEVEL = 6,
    parameter logic [15:0] INTR_VECT  = 16'o000254
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        devRESET,
    input  logic        rhCLR,
    input  logic        rhcs1WRITE,
    input  logic        devLOBYTE,
    input  logic [0:35] devDATAI,
    input  logic [15:0] rhCS1,
    input  logic        devINTA,
    output logic [7:1]  devINTR,
    output logic [15:0] devVECT,
    output logic        rhIACK,
    output logic        rhPEND
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        pend_q, pend_d;
    logic        last_rdy_q, last_sc_q;
    logic [7:1]  intr_q, intr_d;
    logic [15:0] vect_q, vect_d;
    logic        iack_q, iack_d;
    logic        rhpend_q, rhpend_d;
    logic [7:1]  lvl_bit;

    logic clr, sc, rdy, ie, wr_ie, wr_rdy;
    logic ev_done, ev_attn, ev_wr, ev;
    logic unused_bits;

    assign clr    = devRESET | rhCLR;
    assign sc     = rhCS1[15];
    assign rdy    = rhCS1[7];
    assign ie     = rhCS1[6];
    // Big-endian data bus: little-endian bit n lives at index 35-n.
    assign wr_ie  = devDATAI[29];
    assign wr_rdy = devDATAI[28];

    assign ev_done = rdy & ~last_rdy_q & ie;
    assign ev_attn = sc & ~last_sc_q & rdy & ie;
    assign ev_wr   = rhcs1WRITE & devLOBYTE & wr_ie & wr_rdy & rdy;
    assign ev      = ev_done | ev_attn | ev_wr;

    assign unused_bits = ^{devDATAI[0:27], devDATAI[30:35], rhCS1[14:8], rhCS1[5:0]};

    always_comb begin
        lvl_bit             = '0;
        lvl_bit[INTR_LEVEL] = 1'b1;
    end

    // State, pending and edge registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            last_rdy_q <= 1'b1;
            last_sc_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            last_rdy_q <= rdy;
            last_sc_q  <= clr ? 1'b0 : sc;
        end
    end

    // Next state and pending
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        if (clr) begin
            state_d = IDLE;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (pend_q) state_d = REQ;
                REQ: begin
                    // A grant always wins, even if software just dropped IE.
                    if (devINTA)        state_d = ACK;
                    else if (!ie && !ev) state_d = IDLE;
                end
                ACK:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (ev)
                pend_d = 1'b1;
            else if (state_q == ACK)
                pend_d = 1'b0;
            else if (state_q == REQ && !devINTA && !ie)
                pend_d = 1'b0;
        end
    end

    // Outputs decoded from the next state so they leave straight from flops
    always_comb begin
        intr_d   = (state_d == REQ) ? lvl_bit : '0;
        vect_d   = (state_d == ACK) ? INTR_VECT : 16'd0;
        iack_d   = (state_d == ACK);
        rhpend_d = pend_d | (state_d == REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intr_q   <= '0;
            vect_q   <= '0;
            iack_q   <= 1'b0;
            rhpend_q <= 1'b0;
        end else begin
            intr_q   <= intr_d;
            vect_q   <= vect_d;
            iack_q   <= iack_d;
            rhpend_q <= rhpend_d;
        end
    end

    assign devINTR = intr_q;
    assign devVECT = vect_q;
    assign rhIACK  = iack_q;
    assign rhPEND  = rhpend_q;

endmodule
